// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main control unit and its datapath.
// The controller is the master: it reads the opcode and the memory handshake
// and drives every mux select, enable and debug signal.
interface multicycle_control_if #(
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 32
);
  logic [6:0]         opcode_i;
  logic               mem_ready_i;
  logic               pcwrite_o;
  logic               irwrite_o;
  logic               adrsrc_o;
  logic               memread_o;
  logic               memwrite_o;
  logic               regwrite_o;
  logic               branch_o;
  logic [1:0]         alusrca_o;
  logic [1:0]         alusrcb_o;
  logic [1:0]         resultsrc_o;
  logic [ALUOP_W-1:0] aluop_o;
  logic [3:0]         state_o;
  logic               illegal_o;
  logic [CNT_W-1:0]   instret_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output pcwrite_o, irwrite_o, adrsrc_o, memread_o, memwrite_o, regwrite_o,
           branch_o, alusrca_o, alusrcb_o, resultsrc_o, aluop_o, state_o,
           illegal_o, instret_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  pcwrite_o, irwrite_o, adrsrc_o, memread_o, memwrite_o, regwrite_o,
           branch_o, alusrca_o, alusrcb_o, resultsrc_o, aluop_o, state_o,
           illegal_o, instret_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control unit of the multicycle RV32I core.
// A Moore FSM sequences fetch, decode, execute, memory and writeback, waits on
// the memory ready handshake, traps or skips illegal opcodes and counts retired
// instructions. Control outputs are registered alongside the state; only the
// FETCH-cycle PC/IR load follows mem_ready_i directly, and reset masks every
// control output in the same cycle it is asserted.
module multicycle_control #(
  parameter int ALUOP_W         = 5,
  parameter int CNT_W           = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter bit ENABLE_JAL      = 1'b1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_R   = 5'b01100;
  localparam logic [4:0] ALU_I   = 5'b00100;
  localparam logic [4:0] ALU_B   = 5'b11000;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Registered control word; 'fetch' marks the state whose PC/IR loads
  // are gated by the memory handshake rather than fixed by the state.
  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       branch;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [4:0] aluop;
    logic       illegal;
    logic       fetch;
  } ctrl_t;

  // Control word that belongs to a given state; anything not set stays 0.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch     = 1'b1;
        c.memread   = 1'b1;
        c.adrsrc    = 1'b0;
        c.alusrca   = SRCA_PC;
        c.alusrcb   = SRCB_FOUR;
        c.aluop     = ALU_ADD;
        c.resultsrc = RES_ALU;
      end
      DECODE: begin
        c.alusrca = SRCA_OLDPC;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALU_ADD;
      end
      MEMADR: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALU_ADD;
      end
      MEMREAD: begin
        c.memread   = 1'b1;
        c.adrsrc    = 1'b1;
        c.resultsrc = RES_ALUOUT;
      end
      MEMWB: begin
        c.regwrite  = 1'b1;
        c.resultsrc = RES_MEM;
      end
      MEMWRITE: begin
        c.memwrite  = 1'b1;
        c.adrsrc    = 1'b1;
        c.resultsrc = RES_ALUOUT;
      end
      EXECR: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_RS2;
        c.aluop   = ALU_R;
      end
      EXECI: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALU_I;
      end
      ALUWB: begin
        c.regwrite  = 1'b1;
        c.resultsrc = RES_ALUOUT;
      end
      BRANCH: begin
        c.alusrca   = SRCA_RS1;
        c.alusrcb   = SRCB_RS2;
        c.aluop     = ALU_B;
        c.resultsrc = RES_ALUOUT;
        c.branch    = 1'b1;
      end
      JAL: begin
        c.alusrca   = SRCA_OLDPC;
        c.alusrcb   = SRCB_FOUR;
        c.aluop     = ALU_ADD;
        c.resultsrc = RES_ALUOUT;
        c.pcwrite   = 1'b1;
      end
      TRAP: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t           state;
  state_t           next_state;
  logic             retire;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] instret;
  logic             fetch_ready;

  // Next-state selection; 'retire' flags every transition that completes an
  // instruction and lands back in FETCH.
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        if (bus.mem_ready_i) next_state = DECODE;
      end
      DECODE: begin
        if (bus.opcode_i == OP_LOAD || bus.opcode_i == OP_STORE) begin
          next_state = MEMADR;
        end else if (bus.opcode_i == OP_RTYPE) begin
          next_state = EXECR;
        end else if (bus.opcode_i == OP_ITYPE) begin
          next_state = EXECI;
        end else if (bus.opcode_i == OP_BRANCH) begin
          next_state = BRANCH;
        end else if (ENABLE_JAL && bus.opcode_i == OP_JAL) begin
          next_state = JAL;
        end else if (TRAP_ON_ILLEGAL) begin
          next_state = TRAP;
        end else begin
          next_state = FETCH;
          retire     = 1'b1;
        end
      end
      MEMADR: begin
        next_state = (bus.opcode_i == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        if (bus.mem_ready_i) next_state = MEMWB;
      end
      MEMWB: begin
        next_state = FETCH;
        retire     = 1'b1;
      end
      MEMWRITE: begin
        if (bus.mem_ready_i) begin
          next_state = FETCH;
          retire     = 1'b1;
        end
      end
      EXECR:  next_state = ALUWB;
      EXECI:  next_state = ALUWB;
      ALUWB: begin
        next_state = FETCH;
        retire     = 1'b1;
      end
      BRANCH: begin
        next_state = FETCH;
        retire     = 1'b1;
      end
      JAL:    next_state = ALUWB;
      TRAP:   next_state = TRAP;
      default: next_state = FETCH;
    endcase
  end

  // State, registered control word and retired-instruction counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= FETCH;
      ctrl    <= ctrl_for(FETCH);
      instret <= '0;
    end else begin
      state <= next_state;
      ctrl  <= ctrl_for(next_state);
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  assign fetch_ready = ctrl.fetch & bus.mem_ready_i;

  assign bus.pcwrite_o   = ~rst_i & (ctrl.pcwrite | fetch_ready);
  assign bus.irwrite_o   = ~rst_i & fetch_ready;
  assign bus.adrsrc_o    = ~rst_i & ctrl.adrsrc;
  assign bus.memread_o   = ~rst_i & ctrl.memread;
  assign bus.memwrite_o  = ~rst_i & ctrl.memwrite;
  assign bus.regwrite_o  = ~rst_i & ctrl.regwrite;
  assign bus.branch_o    = ~rst_i & ctrl.branch;
  assign bus.illegal_o   = ~rst_i & ctrl.illegal;
  assign bus.alusrca_o   = rst_i ? 2'b00 : ctrl.alusrca;
  assign bus.alusrcb_o   = rst_i ? 2'b00 : ctrl.alusrcb;
  assign bus.resultsrc_o = rst_i ? 2'b00 : ctrl.resultsrc;
  assign bus.aluop_o     = rst_i ? '0 : ALUOP_W'(ctrl.aluop);
  assign bus.state_o     = state;
  assign bus.instret_o   = instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Three instances with different parameter sets share one stimulus; a selector
// picks which one is observed. Expected behaviour comes from per-class state
// paths and a per-state output table, plus a latency vector table.
module tb_multicycle_control;

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
  localparam int S_ER = 6, S_EI = 7, S_AWB = 8, S_BR = 9, S_J = 10, S_T = 11;

  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       adrsrc;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       branch;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [7:0] aluop;
    logic       illegal;
  } obs_t;

  typedef struct {
    logic [6:0] op;
    int         exp_cycles;
    int         exp_retire;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        ready;
  int          sel;
  int          n_checks;
  int          n_fail;
  bit          cfg_trap;
  bit          cfg_jal;
  logic [31:0] cfg_mask;
  logic [31:0] model_ret;

  obs_t        obs;
  logic [3:0]  obs_state;
  logic [31:0] obs_instret;

  always #5 clk = ~clk;

  multicycle_control_if #(.ALUOP_W(5), .CNT_W(32)) bus0 ();
  multicycle_control_if #(.ALUOP_W(8), .CNT_W(32)) bus1 ();
  multicycle_control_if #(.ALUOP_W(5), .CNT_W(4))  bus2 ();

  assign bus0.opcode_i = opcode;
  assign bus1.opcode_i = opcode;
  assign bus2.opcode_i = opcode;
  assign bus0.mem_ready_i = ready;
  assign bus1.mem_ready_i = ready;
  assign bus2.mem_ready_i = ready;

  multicycle_control #(.ALUOP_W(5), .CNT_W(32), .TRAP_ON_ILLEGAL(1'b1), .ENABLE_JAL(1'b1))
    dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  multicycle_control #(.ALUOP_W(8), .CNT_W(32), .TRAP_ON_ILLEGAL(1'b0), .ENABLE_JAL(1'b1))
    dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
  multicycle_control #(.ALUOP_W(5), .CNT_W(4), .TRAP_ON_ILLEGAL(1'b1), .ENABLE_JAL(1'b0))
    dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  // Observe the selected instance through one common view.
  always_comb begin
    obs         = '0;
    obs_state   = '0;
    obs_instret = '0;
    case (sel)
      0: begin
        obs = '{bus0.pcwrite_o, bus0.irwrite_o, bus0.adrsrc_o, bus0.memread_o,
                bus0.memwrite_o, bus0.regwrite_o, bus0.branch_o, bus0.alusrca_o,
                bus0.alusrcb_o, bus0.resultsrc_o, {3'b000, bus0.aluop_o}, bus0.illegal_o};
        obs_state   = bus0.state_o;
        obs_instret = bus0.instret_o;
      end
      1: begin
        obs = '{bus1.pcwrite_o, bus1.irwrite_o, bus1.adrsrc_o, bus1.memread_o,
                bus1.memwrite_o, bus1.regwrite_o, bus1.branch_o, bus1.alusrca_o,
                bus1.alusrcb_o, bus1.resultsrc_o, bus1.aluop_o, bus1.illegal_o};
        obs_state   = bus1.state_o;
        obs_instret = bus1.instret_o;
      end
      2: begin
        obs = '{bus2.pcwrite_o, bus2.irwrite_o, bus2.adrsrc_o, bus2.memread_o,
                bus2.memwrite_o, bus2.regwrite_o, bus2.branch_o, bus2.alusrca_o,
                bus2.alusrcb_o, bus2.resultsrc_o, {3'b000, bus2.aluop_o}, bus2.illegal_o};
        obs_state   = bus2.state_o;
        obs_instret = {28'd0, bus2.instret_o};
      end
      default: ;
    endcase
  end

  // Output table per state, as the control unit's contract describes it.
  function automatic obs_t exp_ctrl(input int s, input logic rdy);
    obs_t e;
    e = '0;
    case (s)
      S_F:   begin e.memread = 1'b1; e.alusrcb = 2'b10; e.resultsrc = 2'b10;
                   e.irwrite = rdy; e.pcwrite = rdy; end
      S_D:   begin e.alusrca = 2'b01; e.alusrcb = 2'b01; end
      S_MA:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
      S_MR:  begin e.memread = 1'b1; e.adrsrc = 1'b1; end
      S_MWB: begin e.regwrite = 1'b1; e.resultsrc = 2'b01; end
      S_MW:  begin e.memwrite = 1'b1; e.adrsrc = 1'b1; end
      S_ER:  begin e.alusrca = 2'b10; e.aluop = 8'b01100; end
      S_EI:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; e.aluop = 8'b00100; end
      S_AWB: begin e.regwrite = 1'b1; end
      S_BR:  begin e.alusrca = 2'b10; e.aluop = 8'b11000; e.branch = 1'b1; end
      S_J:   begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1'b1; end
      S_T:   begin e.illegal = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_output(input string tag, input int exp_state, input logic [31:0] exp_ret);
    obs_t        e;
    logic [31:0] r;
    e = exp_ctrl(exp_state, ready);
    r = exp_ret & cfg_mask;
    n_checks++;
    if (obs_state !== 4'(exp_state)) begin
      n_fail++;
      $display("[TB] FAIL %s state: got %0d want %0d", tag, obs_state, exp_state);
    end
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("[TB] FAIL %s outputs (state %0d): got %h want %h", tag, exp_state, obs, e);
    end
    n_checks++;
    if (obs_instret !== r) begin
      n_fail++;
      $display("[TB] FAIL %s instret: got %0d want %0d", tag, obs_instret, r);
    end
  endtask

  task automatic step(input string tag, input int exp_state);
    @(negedge clk);
    check_output(tag, exp_state, model_ret);
    @(posedge clk);
    #1;
  endtask

  task automatic check_forced(input string tag);
    @(negedge clk);
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("[TB] FAIL %s outputs under reset: got %h want 0", tag, obs);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    ready  = 1'b0;
    opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    model_ret = '0;
  endtask

  // One instruction: the state path follows from the opcode class, each wait
  // state may stall; opcode is garbage outside DECODE/MEMADR.
  task automatic apply_stimulus(input string tag, input logic [6:0] op,
                                input int fetch_stall, input int mem_stall, input bit rand_mode);
    int path[$];
    path.push_back(S_F);
    path.push_back(S_D);
    case (op)
      OP_L: begin path.push_back(S_MA); path.push_back(S_MR); path.push_back(S_MWB); end
      OP_S: begin path.push_back(S_MA); path.push_back(S_MW); end
      OP_R: begin path.push_back(S_ER); path.push_back(S_AWB); end
      OP_I: begin path.push_back(S_EI); path.push_back(S_AWB); end
      OP_B: path.push_back(S_BR);
      OP_J: begin
        if (cfg_jal) begin path.push_back(S_J); path.push_back(S_AWB); end
        else if (cfg_trap) path.push_back(S_T);
      end
      default: if (cfg_trap) path.push_back(S_T);
    endcase
    foreach (path[p]) begin
      int s;
      bit waits;
      int stalls;
      s     = path[p];
      waits = (s == S_F || s == S_MR || s == S_MW);
      if (!waits) stalls = 0;
      else if (rand_mode) stalls = $urandom_range(0, 3);
      else stalls = (s == S_F) ? fetch_stall : mem_stall;
      for (int k = 0; k <= stalls; k++) begin
        if (waits) ready = (k == stalls);
        else ready = rand_mode ? 1'($urandom) : 1'b1;
        opcode = (s == S_D || s == S_MA) ? op : 7'($urandom);
        step(tag, s);
      end
    end
    if (path[path.size()-1] != S_T) model_ret++;
  endtask

  // Latency/retire table with mem_ready held high, on the TRAP_ON_ILLEGAL=0 instance.
  task automatic run_table();
    vec_t vecs[9];
    vecs[0] = '{OP_R, 4, 1};
    vecs[1] = '{OP_I, 4, 1};
    vecs[2] = '{OP_L, 5, 1};
    vecs[3] = '{OP_S, 4, 1};
    vecs[4] = '{OP_B, 3, 1};
    vecs[5] = '{OP_J, 4, 1};
    vecs[6] = '{OP_BAD, 2, 1};
    vecs[7] = '{7'b0000000, 2, 1};
    vecs[8] = '{7'b1100111, 2, 1};
    for (int v = 0; v < 9; v++) begin
      int n;
      n      = 0;
      opcode = vecs[v].op;
      ready  = 1'b1;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (obs_state != 4'd0 && n < 20);
      model_ret = model_ret + 32'(vecs[v].exp_retire);
      n_checks++;
      if (n != vecs[v].exp_cycles) begin
        n_fail++;
        $display("[TB] FAIL table[%0d] op %b latency: got %0d want %0d", v, vecs[v].op, n, vecs[v].exp_cycles);
      end
      n_checks++;
      if (obs_instret !== model_ret) begin
        n_fail++;
        $display("[TB] FAIL table[%0d] op %b instret: got %0d want %0d", v, vecs[v].op, obs_instret, model_ret);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    sel       = 0;
    cfg_trap  = 1'b1;
    cfg_jal   = 1'b1;
    cfg_mask  = 32'hFFFF_FFFF;
    model_ret = '0;
    rst       = 1'b1;
    ready     = 1'b0;
    opcode    = '0;

    // Reset during a store's MEMWRITE with mem_ready high.
    do_reset();
    apply_stimulus("t1_rtype", OP_R, 0, 0, 1'b0);
    opcode = OP_S;
    ready  = 1'b1;
    step("t1_st_fetch", S_F);
    step("t1_st_decode", S_D);
    step("t1_st_memadr", S_MA);
    rst   = 1'b1;
    ready = 1'b1;
    check_forced("t1_rst_memwrite");
    check_forced("t1_rst_hold");
    rst       = 1'b0;
    ready     = 1'b0;
    model_ret = '0;
    step("t1_after_reset", S_F);

    // R-type path and retire.
    do_reset();
    apply_stimulus("t2_rtype", OP_R, 0, 0, 1'b0);
    ready = 1'b0;
    step("t2_retired", S_F);

    // Load with three MEMREAD stalls.
    do_reset();
    apply_stimulus("t3_load", OP_L, 0, 3, 1'b0);
    ready = 1'b0;
    step("t3_retired", S_F);

    // Branch then store.
    do_reset();
    apply_stimulus("t4_branch", OP_B, 0, 0, 1'b0);
    apply_stimulus("t4_store", OP_S, 1, 2, 1'b0);
    ready = 1'b0;
    step("t4_two_retired", S_F);

    // Illegal opcode traps and stays.
    do_reset();
    apply_stimulus("t5_trap", OP_BAD, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ready  = 1'($urandom);
      opcode = 7'($urandom);
      step("t5_trap_hold", S_T);
    end

    // Illegal opcode retires as a NOP when trapping is disabled.
    sel      = 1;
    cfg_trap = 1'b0;
    do_reset();
    apply_stimulus("t6_nop", OP_BAD, 0, 0, 1'b0);
    ready = 1'b0;
    step("t6_retired", S_F);

    run_table();

    // Randomized instruction mix with random stalls.
    for (int i = 0; i < 60; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 6))
        0: op = OP_L;
        1: op = OP_S;
        2: op = OP_R;
        3: op = OP_I;
        4: op = OP_B;
        5: op = OP_J;
        default: op = 7'($urandom);
      endcase
      apply_stimulus("rand", op, 0, 0, 1'b1);
    end
    ready = 1'b0;
    step("rand_end", S_F);

    // 4-bit counter wrap, then JAL disabled traps.
    sel      = 2;
    cfg_trap = 1'b1;
    cfg_jal  = 1'b0;
    cfg_mask = 32'h0000_000F;
    do_reset();
    for (int i = 0; i < 16; i++) apply_stimulus("t7_itype", OP_I, 0, 0, 1'b0);
    ready = 1'b0;
    step("t7_wrapped", S_F);
    apply_stimulus("t7_jal_trap", OP_J, 0, 0, 1'b0);
    step("t7_jal_hold", S_T);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
